// File: rtl/cpu_controller.sv
// Purpose : sequencing controller for a 4-word, 4-bit-instruction accumulator CPU (FETCH/DECODE/EXECUTE/HALT).
// Latency : 3 cycles per instruction in free-run; strobes are valid only during the EXECUTE cycle.
// Backpressure: none; in single-step mode FETCH stalls until step is high, and HALT stalls until reset.
//
// Ports:
//   clk, reset        - system clock (rising edge); asynchronous active-high reset
//   run, step         - free-run enable; level-sensitive single-step request (sampled in FETCH only)
//   instr_data[3:0]   - ROM word at instr_addr: [3:2] opcode, [1:0] operand
//   instr_addr[1:0]   - program counter
//   imm[1:0]          - operand of the current instruction (ir[1:0])
//   acc_we, acc_sel   - accumulator write strobe; source select (0 = imm, 1 = acc + imm)
//   out_we            - output-register write strobe
//   halted, state     - HALT indication; FSM state (00 FETCH, 01 DECODE, 10 EXECUTE, 11 HALT)
//   retired[3:0]      - executed-instruction count, wraps modulo 16
module cpu_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       step,
    input  logic [3:0] instr_data,
    output logic [1:0] instr_addr,
    output logic [1:0] imm,
    output logic       acc_we,
    output logic       acc_sel,
    output logic       out_we,
    output logic       halted,
    output logic [1:0] state,
    output logic [3:0] retired
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'b00,
        S_DECODE  = 2'b01,
        S_EXECUTE = 2'b10,
        S_HALT    = 2'b11
    } state_t;

    localparam logic [1:0] OP_LDI = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_OUT = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;   // operand 11 encodes HALT

    state_t     state_q;
    logic [1:0] pc;
    logic [3:0] ir;
    logic [3:0] retired_q;

    wire [1:0] opcode  = ir[3:2];
    wire [1:0] operand = ir[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc        <= 2'd0;
            ir        <= 4'd0;
            retired_q <= 4'd0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    // step is a level: holding it high advances one instruction per FETCH visit
                    if (run || step) begin
                        ir      <= instr_data;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state_q <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    retired_q <= retired_q + 4'd1;
                    if (opcode == OP_JMP && operand == 2'b11) begin
                        state_q <= S_HALT;
                    end else begin
                        if (opcode == OP_JMP) begin
                            pc <= operand;
                        end else begin
                            pc <= pc + 2'd1;
                        end
                        state_q <= S_FETCH;
                    end
                end
                S_HALT: begin
                    // absorbing; only reset leaves
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    // Strobes decode directly from the EXECUTE state so reset removes them without waiting for a clock.
    always_comb begin
        acc_we  = 1'b0;
        acc_sel = 1'b0;
        out_we  = 1'b0;
        if (state_q == S_EXECUTE) begin
            case (opcode)
                OP_LDI:  acc_we = 1'b1;
                OP_ADD: begin
                    acc_we  = 1'b1;
                    acc_sel = 1'b1;
                end
                OP_OUT:  out_we = 1'b1;
                default: ;
            endcase
        end
    end

    assign instr_addr = pc;
    assign imm        = ir[1:0];
    assign halted     = (state_q == S_HALT);
    assign state      = state_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_cpu_controller.sv
module tb_cpu_controller;

    logic       clk;
    logic       reset;
    logic       run;
    logic       step;
    logic [3:0] instr_data;
    logic [1:0] instr_addr;
    logic [1:0] imm;
    logic       acc_we;
    logic       acc_sel;
    logic       out_we;
    logic       halted;
    logic [1:0] state;
    logic [3:0] retired;

    cpu_controller dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .instr_data (instr_data),
        .instr_addr (instr_addr),
        .imm        (imm),
        .acc_we     (acc_we),
        .acc_sel    (acc_sel),
        .out_we     (out_we),
        .halted     (halted),
        .state      (state),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // program ROM, or random garbage on the bus when use_rand is set
    logic [3:0] rom [4];
    logic       use_rand;
    logic [3:0] rnd_data;
    assign instr_data = use_rand ? rnd_data : rom[instr_addr];

    int n_checks;
    int n_errors;

    // Instruction-level reference model: phase 0 fetch, 1 decode, 2 execute, 3 halted.
    int m_pc, m_ir, m_phase, m_ret;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_phase = 0; m_ret = 0;
    endtask

    // Advance the model by one clock using the inputs present just before the edge.
    task automatic model_edge();
        int op, opd, word;
        word = use_rand ? int'(rnd_data) : int'(rom[m_pc]);
        op   = m_ir / 4;
        opd  = m_ir % 4;
        if (m_phase == 0) begin
            if (run || step) begin
                m_ir    = word;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2) begin
            m_ret = (m_ret + 1) % 16;
            if (op == 3 && opd == 3) begin
                m_phase = 3;
            end else begin
                m_pc    = (op == 3) ? opd : (m_pc + 1) % 4;
                m_phase = 0;
            end
        end
    endtask

    task automatic compare_all(input string name);
        int op;
        logic [13:0] exp_v, act_v;
        logic ex;
        op = m_ir / 4;
        ex = (m_phase == 2);
        exp_v = {2'(m_phase), 2'(m_pc), 2'(m_ir % 4),
                 ex && (op <= 1), ex && (op == 1), ex && (op == 2),
                 (m_phase == 3), 4'(m_ret)};
        act_v = {state, instr_addr, imm, acc_we, acc_sel, out_we, halted, retired};
        check(name, int'(act_v), int'(exp_v));
    endtask

    task automatic tick(input string name);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(name);
    endtask

    task automatic load_prog(input logic [15:0] prog);
        for (int i = 0; i < 4; i++) rom[i] = prog[15 - 4*i -: 4];
    endtask

    // Reset asserted and released away from the rising edge; returns just after a falling edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        run   = 1'b0;
        step  = 1'b0;
        use_rand = 1'b0;
        #1;
        model_reset();
        compare_all("reset_outputs");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [15:0] prog;
        logic        run;
        logic        step;
        int          edges;
        int          exp_state;
        int          exp_pc;
        int          exp_ret;
    } vec_t;

    vec_t tv [7];

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        run      = 1'b0;
        step     = 1'b0;
        use_rand = 1'b0;
        rnd_data = 4'h0;
        load_prog(16'h168F);
        model_reset();
        #2;
        compare_all("power_on_reset");

        // ---------------- table-driven programs ----------------
        tv[0] = '{16'h168F, 1'b1, 1'b0, 12, 3, 3, 4};   // LDI1 ADD2 OUT HALT
        tv[1] = '{16'h28C0, 1'b1, 1'b0, 48, 0, 1, 0};   // LDI2 OUT JMP0: 16 instrs, retired wraps
        tv[2] = '{16'h5555, 1'b1, 1'b0, 15, 0, 1, 5};   // four ADDs, pc wraps 3->0
        tv[3] = '{16'h0000, 1'b0, 1'b1,  9, 0, 3, 3};   // step held high: one instr per FETCH
        tv[4] = '{16'h1234, 1'b0, 1'b0, 10, 0, 0, 0};   // no run/step: frozen in FETCH
        tv[5] = '{16'hF000, 1'b1, 1'b0, 23, 3, 0, 1};   // immediate HALT, stays halted
        tv[6] = '{16'hE0F0, 1'b1, 1'b0,  6, 3, 2, 2};   // JMP 2 then HALT
        for (int v = 0; v < 7; v++) begin
            load_prog(tv[v].prog);
            do_reset();
            run  = tv[v].run;
            step = tv[v].step;
            for (int e = 0; e < tv[v].edges; e++) tick("table_cycle");
            check("table_state",   int'(state),      tv[v].exp_state);
            check("table_pc",      int'(instr_addr), tv[v].exp_pc);
            check("table_retired", int'(retired),    tv[v].exp_ret);
        end

        // ---------------- strobe timing of the reference program ----------------
        load_prog(16'h168F);
        do_reset();
        run = 1'b1;
        #1;
        for (int c = 1; c <= 14; c++) begin
            check("t_acc_we",  int'(acc_we),  int'(c == 3 || c == 6));
            check("t_acc_sel", int'(acc_sel), int'(c == 6));
            check("t_out_we",  int'(out_we),  int'(c == 9));
            check("t_halted",  int'(halted),  int'(c >= 13));
            tick("timing_cycle");
        end

        // ---------------- asynchronous reset during EXECUTE ----------------
        load_prog(16'h5555);
        do_reset();
        run = 1'b1;
        for (int e = 0; e < 11; e++) tick("pre_reset_cycle");
        check("pre_reset_state",   int'(state),   2);
        check("pre_reset_retired", int'(retired), 3);
        check("pre_reset_acc_we",  int'(acc_we),  1);
        #2;
        reset = 1'b1;
        #1;
        check("async_state",   int'(state),                     0);
        check("async_pc",      int'(instr_addr),                0);
        check("async_retired", int'(retired),                   0);
        check("async_strobes", int'({acc_we, acc_sel, out_we}), 0);
        do_reset();

        // ---------------- HALT is absorbing ----------------
        load_prog(16'h4F00);
        do_reset();
        run = 1'b1;
        for (int e = 0; e < 6; e++) tick("halt_entry");
        use_rand = 1'b1;
        for (int e = 0; e < 20; e++) begin
            run      = 1'($urandom);
            step     = 1'($urandom);
            rnd_data = 4'($urandom);
            tick("halt_cycle");
            check("halt_hold", int'({state, instr_addr, retired, acc_we, out_we}), int'({2'd3, 2'd1, 4'd2, 2'b00}));
        end
        use_rand = 1'b0;

        // ---------------- single-step pulses ----------------
        load_prog(16'h1689);
        do_reset();
        for (int e = 0; e < 4; e++) tick("step_idle");
        check("step_idle_retired", int'(retired), 0);
        for (int p = 1; p <= 3; p++) begin
            step = 1'b1;
            tick("step_pulse");
            step = 1'b0;
            for (int e = 0; e < 6; e++) tick("step_wait");
            check("step_retired", int'(retired),    p);
            check("step_pc",      int'(instr_addr), p);
            check("step_state",   int'(state),      0);
        end

        // ---------------- randomized programs and run/step ----------------
        for (int s = 0; s < 40; s++) begin
            for (int i = 0; i < 4; i++) rom[i] = 4'($urandom);
            do_reset();
            for (int e = 0; e < 60; e++) begin
                run  = ($urandom_range(0, 3) == 0);
                step = 1'($urandom);
                tick("random_cycle");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
